inst_encoder: RTL and testbench

- Field-to-word RV32I instruction encoder, the inverse of the core's instruction decoder.
- Accepts field-level requests and emits 32-bit instruction words into an output FIFO, drained by a valid/ready consumer (debug injector or boot-ROM loader feeding fetch).
- Expands the LI pseudo-op into LUI+ADDI over two cycles.

---
 rtl/inst_encoder.sv | 172 +++++++++++++++++
 tb/tb_inst_encoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I field-to-word encoder feeding a small output FIFO; LI expands to LUI+ADDI over two cycles.
// Latency 1 cycle from accept to FIFO head; o_ready reserves two free slots so the LI tail always fits.
module inst_encoder #(
  parameter int DEPTH     = 4,
  parameter bit ADDI_SEXT = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [2:0]                 i_fmt,
  input  logic [6:0]                 i_op,
  input  logic [4:0]                 i_rd,
  input  logic [4:0]                 i_rs1,
  input  logic [4:0]                 i_rs2,
  input  logic [2:0]                 i_funct3,
  input  logic [6:0]                 i_funct7,
  input  logic [31:0]                i_imm,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [31:0]                o_inst,
  output logic                       o_last,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_LI  = 3'd6;
  localparam logic [2:0] FMT_SYS = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic {S_IDLE, S_EXP} state_t;

  state_t            state, state_nxt;
  logic [31:0]       pend_word;

  logic [31:0]       enc_word;
  logic              enc_last;
  logic              enc_exp;
  logic [31:0]       exp_word;
  logic              li_short;
  logic [19:0]       li_hi;

  logic              accept;
  logic              pop;
  logic              push;
  logic [31:0]       push_word;
  logic              push_last;

  logic [32:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       space_chk;
  logic [32:0]       head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Field packing; LI picks the short ADDI form when the value fits the consumer's immediate extension.
  always_comb begin
    enc_word = '0;
    enc_last = 1'b1;
    enc_exp  = 1'b0;
    exp_word = {i_imm[11:0], i_rd, 3'b000, i_rd, OP_IMM};
    li_short = ADDI_SEXT ? ((&i_imm[31:11]) | ~(|i_imm[31:11])) : ~(|i_imm[31:12]);
    li_hi    = ADDI_SEXT ? (i_imm[31:12] + {19'd0, i_imm[11]}) : i_imm[31:12];
    case (i_fmt)
      FMT_R: enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_op};
      FMT_I: begin
        if (i_op == OP_IMM && i_funct3[1:0] == 2'b01)
          enc_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_op};
        else
          enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
      end
      FMT_S: enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_op};
      FMT_B: enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                         i_imm[4:1], i_imm[11], i_op};
      FMT_U: enc_word = {i_imm[31:12], i_rd, i_op};
      FMT_J: enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_op};
      FMT_LI: begin
        if (li_short) begin
          enc_word = {i_imm[11:0], 5'd0, 3'b000, i_rd, OP_IMM};
        end else begin
          enc_word = {li_hi, i_rd, OP_LUI};
          if (i_imm[11:0] != 12'd0) begin
            enc_last = 1'b0;
            enc_exp  = 1'b1;
          end
        end
      end
      FMT_SYS: enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_SYSTEM};
      default: enc_word = '0;
    endcase
  end

  assign o_valid   = (count != '0);
  assign pop       = o_valid && i_ready;
  assign space_chk = {1'b0, count} + (CW+1)'(pop);
  // Reserving two slots (and counting a same-cycle pop against us) keeps the EXP push unconditional.
  assign o_ready   = i_rst_n && (state == S_IDLE) && (space_chk <= (CW+1)'(DEPTH - 2));
  assign accept    = i_valid && o_ready;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_word = enc_word;
    push_last = enc_last;
    case (state)
      S_IDLE: begin
        if (accept) begin
          push = 1'b1;
          if (enc_exp) state_nxt = S_EXP;
        end
      end
      S_EXP: begin
        push      = 1'b1;
        push_word = pend_word;
        push_last = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      pend_word <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && accept && enc_exp) pend_word <= exp_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_word};
  end

  // Head is gated so stale storage never shows while the FIFO is empty or in reset.
  assign head    = mem[rd_ptr];
  assign o_inst  = o_valid ? head[31:0] : 32'd0;
  assign o_last  = o_valid ? head[32] : 1'b0;
  assign o_count = count;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, LI expansion, backpressure/wrap, reset mid-expansion.
module tb_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        valid, rdy, ovld, cons_rdy, last;
  logic [2:0]  fmt, f3;
  logic [6:0]  op, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, inst;
  logic [2:0]  cnt;

  logic        v0, rdy0, ovld0, last0;
  logic [31:0] inst0;
  logic [2:0]  cnt0;

  int checks = 0;
  int errors = 0;

  inst_encoder #(.DEPTH(4), .ADDI_SEXT(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy),
    .i_fmt(fmt), .i_op(op), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
    .i_funct3(f3), .i_funct7(f7), .i_imm(imm),
    .o_valid(ovld), .i_ready(cons_rdy), .o_inst(inst), .o_last(last), .o_count(cnt)
  );

  inst_encoder #(.DEPTH(4), .ADDI_SEXT(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .o_ready(rdy0),
    .i_fmt(fmt), .i_op(op), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
    .i_funct3(f3), .i_funct7(f7), .i_imm(imm),
    .o_valid(ovld0), .i_ready(1'b1), .o_inst(inst0), .o_last(last0), .o_count(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                         input logic [6:0] fn7, input logic [31:0] im);
    fmt = f; op = o; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold valid until accepted (bounded), return 1 ns after the accept edge.
  task automatic send(input string tag);
    int n;
    n = 0;
    valid = 1'b1;
    while (!rdy && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " accept"}, 32'(rdy), 32'd1);
    tick();
    valid = 1'b0;
  endtask

  task automatic one_word(input string tag, input logic [31:0] exp);
    send(tag);
    chk(tag, inst, exp);
    chk({tag, " last"}, 32'(last), 32'd1);
    tick();
  endtask

  function automatic logic [31:0] rword(input logic [4:0] k);
    return {7'd0, k, k, 3'b000, k, 7'b0110011};
  endfunction

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [4:0]  k;
    int          cyc;
    int          popped;
    logic        saw;

    rst_n = 1'b1; valid = 1'b0; v0 = 1'b0; cons_rdy = 1'b1;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #1 rst_n = 1'b0;
    #2;
    chk("rst o_valid", 32'(ovld), 32'd0);
    chk("rst o_count", 32'(cnt), 32'd0);
    chk("rst o_inst", inst, 32'd0);
    chk("rst o_last", 32'(last), 32'd0);
    chk("rst o_ready", 32'(rdy), 32'd0);
    #19 rst_n = 1'b1;
    tick();

    // R-type ADD
    set_req(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send("add");
    chk("add inst", inst, 32'h002081B3);
    chk("add last", 32'(last), 32'd1);
    chk("add valid", 32'(ovld), 32'd1);
    repeat (2) tick();

    // LI needing LUI+ADDI with carry correction
    set_req(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    send("li pair");
    chk("li lui", inst, 32'h123462B7);
    chk("li lui last", 32'(last), 32'd0);
    chk("li exp ready", 32'(rdy), 32'd0);
    tick();
    chk("li addi", inst, 32'hFFF28293);
    chk("li addi last", 32'(last), 32'd1);
    repeat (2) tick();

    set_req(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFB);
    one_word("li neg5", 32'hFFB00293);
    set_req(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00010000);
    one_word("li lui only", 32'h000102B7);
    chk("li lui only no tail", 32'(ovld), 32'd0);

    // Zero-extending consumer: 0xFFF fits a single ADDI
    chk("sext0 ready", 32'(rdy0), 32'd1);
    set_req(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000FFF);
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    chk("sext0 inst", inst0, 32'hFFF00293);
    chk("sext0 last", 32'(last0), 32'd1);
    chk("sext0 count", 32'(cnt0), 32'd1);
    chk("sext0 valid", 32'(ovld0), 32'd1);

    set_req(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    one_word("beq", 32'hFE208EE3);
    set_req(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
    one_word("jal", 32'h001000EF);
    set_req(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    one_word("sw", 32'h0020A423);
    set_req(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd5, 7'b0100000, 32'd3);
    one_word("srai", 32'h40315093);
    set_req(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000302);
    one_word("mret", 32'h30200073);

    // Backpressure: consumer stalled, stream R requests until o_ready drops
    cons_rdy = 1'b0;
    tick();
    chk("bp start count", 32'(cnt), 32'd0);
    k = 5'd1;
    cyc = 0;
    while (cyc < 6) begin
      set_req(3'd0, 7'b0110011, k, k, k, 3'd0, 7'd0, 32'd0);
      valid = 1'b1;
      if (!rdy) break;
      exp_q.push_back(rword(k));
      tick();
      k = k + 5'd1;
      cyc++;
    end
    chk("bp count", 32'(cnt), 32'd3);
    chk("bp ready", 32'(rdy), 32'd0);
    chk("bp head", inst, exp_q[0]);
    repeat (3) tick();
    chk("bp head held", inst, exp_q[0]);
    chk("bp count held", 32'(cnt), 32'd3);

    // Drain while continuing to 12 requests total; pointers wrap several times
    cons_rdy = 1'b1;
    cyc = 0;
    popped = 0;
    while ((k <= 5'd12 || exp_q.size() != 0) && cyc < 80) begin
      if (ovld) begin
        if (exp_q.size() == 0) begin
          chk("drain extra word", 32'(ovld), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("drain order", inst, e);
          popped++;
        end
      end
      if (k <= 5'd12) begin
        set_req(3'd0, 7'b0110011, k, k, k, 3'd0, 7'd0, 32'd0);
        valid = 1'b1;
        if (rdy) begin
          exp_q.push_back(rword(k));
          k = k + 5'd1;
        end
      end else begin
        valid = 1'b0;
      end
      tick();
      cyc++;
    end
    valid = 1'b0;
    chk("drain leftover", 32'(exp_q.size()), 32'd0);
    chk("drain popped", 32'(popped), 32'd12);
    chk("drain count", 32'(cnt), 32'd0);

    // Reset while the LUI is queued and the ADDI is pending
    cons_rdy = 1'b0;
    tick();
    set_req(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send("pre rst add");
    set_req(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    send("pre rst li");
    chk("pre rst count", 32'(cnt), 32'd2);
    chk("pre rst ready", 32'(rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(ovld), 32'd0);
    chk("mid rst count", 32'(cnt), 32'd0);
    chk("mid rst inst", inst, 32'd0);
    chk("mid rst ready", 32'(rdy), 32'd0);
    #10 rst_n = 1'b1;
    cons_rdy = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      tick();
      if (ovld) saw = 1'b1;
    end
    chk("post rst no addi", 32'(saw), 32'd0);
    set_req(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    one_word("post rst add", 32'h002081B3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
